// File: rtl/rv32m_pkg.sv
// Shared types for the RV32M multiply issue controller: op and state
// encodings, the product cache entry layout and the op signedness map.
package rv32m_pkg;

    localparam int unsigned RV_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } mul_state_t;

    typedef struct packed {
        logic                   valid;
        logic [RV_XLEN-1:0]     rs1;
        logic [RV_XLEN-1:0]     rs2;
        logic                   signed_a;
        logic                   signed_b;
        logic [2*RV_XLEN-1:0]   product;
    } mul_cache_t;

    // rs1 is signed for every op except MULHU.
    function automatic logic op_signed_a(mul_op_t op);
        return op != OP_MULHU;
    endfunction

    // rs2 is signed only for MUL and MULH.
    function automatic logic op_signed_b(mul_op_t op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request/response handshake and multiplier side-band of the multiply
// issue controller. slave is the controller view, master the surroundings.
interface mul_issue_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [XLEN-1:0]   req_rs1;
    logic [XLEN-1:0]   req_rs2;
    logic              flush;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic              busy;
    logic              mul_en;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic              mul_signed_a;
    logic              mul_signed_b;
    logic              mul_ready;
    logic [2*XLEN-1:0] mul_out;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
               mul_ready, mul_out,
        output req_ready, resp_valid, resp_data, busy, mul_en, mul_a, mul_b,
               mul_signed_a, mul_signed_b
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
               mul_ready, mul_out,
        input  req_ready, resp_valid, resp_data, busy, mul_en, mul_a, mul_b,
               mul_signed_a, mul_signed_b
    );

endinterface

// File: rtl/mul_result_cache.sv
// One-entry product cache. Remembers the last completed product with its
// operands and signedness and reports whether a new request can reuse it.
module mul_result_cache
    import rv32m_pkg::*;
#(
    parameter int unsigned XLEN     = RV_XLEN,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [XLEN-1:0]   wr_rs1,
    input  logic [XLEN-1:0]   wr_rs2,
    input  logic              wr_signed_a,
    input  logic              wr_signed_b,
    input  logic [2*XLEN-1:0] wr_product,
    input  logic [XLEN-1:0]   lk_rs1,
    input  logic [XLEN-1:0]   lk_rs2,
    input  logic              lk_signed_a,
    input  logic              lk_signed_b,
    input  logic              lk_is_mul,
    output logic              hit,
    output logic [2*XLEN-1:0] hit_product
);

    generate
        if (CACHE_EN) begin : g_cache
            mul_cache_t entry;
            logic       operands_match;
            logic       sign_match;

            // Capture each completed product; reset invalidates the entry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry <= '0;
                end else if (wr_en) begin
                    entry <= '{valid:    1'b1,
                               rs1:      wr_rs1,
                               rs2:      wr_rs2,
                               signed_a: wr_signed_a,
                               signed_b: wr_signed_b,
                               product:  wr_product};
                end
            end

            // The low half is independent of signedness, so MUL only needs
            // the operands to match.
            always_comb begin
                operands_match = entry.valid && (entry.rs1 == lk_rs1) &&
                                 (entry.rs2 == lk_rs2);
                sign_match     = (entry.signed_a == lk_signed_a) &&
                                 (entry.signed_b == lk_signed_b);
                hit            = operands_match && (sign_match || lk_is_mul);
                hit_product    = entry.product;
            end
        end else begin : g_nocache
            assign hit         = 1'b0;
            assign hit_product = '0;
        end
    endgenerate

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between execute and the iterative multiplier: decodes
// the RV32M multiply op, starts the multiplier, selects the result half and
// returns it over valid/ready, short-circuiting through the product cache.
module mul_issue_ctrl
    import rv32m_pkg::*;
#(
    parameter int unsigned XLEN     = RV_XLEN,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    mul_issue_ctrl_if.slave bus
);

    mul_state_t        state;
    mul_op_t           op_q;
    mul_op_t           req_op;
    logic              req_signed_a;
    logic              req_signed_b;
    logic              accept;
    logic              cache_hit;
    logic              cache_wr;
    logic [2*XLEN-1:0] cache_product;

    function automatic logic [XLEN-1:0] select_half(mul_op_t op,
                                                    logic [2*XLEN-1:0] p);
        return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign req_op       = mul_op_t'(bus.req_op);
    assign req_signed_a = op_signed_a(req_op);
    assign req_signed_b = op_signed_b(req_op);
    assign accept       = bus.req_valid && (state == ST_IDLE) && !bus.flush;
    assign cache_wr     = (state == ST_WAIT) && bus.mul_ready && !bus.flush;

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);

    // mul_a/mul_b/mul_signed_* hold the issued request, so they double as
    // the cache write operands when the product arrives.
    mul_result_cache #(
        .XLEN     (XLEN),
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (cache_wr),
        .wr_rs1      (bus.mul_a),
        .wr_rs2      (bus.mul_b),
        .wr_signed_a (bus.mul_signed_a),
        .wr_signed_b (bus.mul_signed_b),
        .wr_product  (bus.mul_out),
        .lk_rs1      (bus.req_rs1),
        .lk_rs2      (bus.req_rs2),
        .lk_signed_a (req_signed_a),
        .lk_signed_b (req_signed_b),
        .lk_is_mul   (req_op == OP_MUL),
        .hit         (cache_hit),
        .hit_product (cache_product)
    );

    // Control FSM with registered start pulse, operands and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            op_q             <= OP_MUL;
            bus.mul_en       <= 1'b0;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= '0;
            bus.mul_a        <= '0;
            bus.mul_b        <= '0;
            bus.mul_signed_a <= 1'b0;
            bus.mul_signed_b <= 1'b0;
        end else begin
            bus.mul_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q             <= req_op;
                        bus.mul_a        <= bus.req_rs1;
                        bus.mul_b        <= bus.req_rs2;
                        bus.mul_signed_a <= req_signed_a;
                        bus.mul_signed_b <= req_signed_b;
                        if (cache_hit) begin
                            bus.resp_data  <= select_half(req_op, cache_product);
                            bus.resp_valid <= 1'b1;
                            state          <= ST_RESP;
                        end else begin
                            bus.mul_en <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= bus.flush ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    // A flush coinciding with completion has nothing left to
                    // drain, so the result is dropped and we return to IDLE.
                    if (bus.mul_ready) begin
                        if (bus.flush) begin
                            state <= ST_IDLE;
                        end else begin
                            bus.resp_data  <= select_half(op_q, bus.mul_out);
                            bus.resp_valid <= 1'b1;
                            state          <= ST_RESP;
                        end
                    end else if (bus.flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    if (bus.flush || bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.mul_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: the bench acts as execute stage,
// consumer and multiplier, predicts every cycle from transaction-level rules
// and a shadow of the product cache.
module tb_mul_issue_ctrl;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_issue_ctrl_if #(.XLEN(XLEN)) bus ();

    mul_issue_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // expectations for the current cycle, checked at the falling edge
    logic        chk_en = 1'b0;
    logic        e_busy = 1'b0;
    logic        e_rv   = 1'b0;
    logic        e_men  = 1'b0;
    logic [31:0] e_data = '0;
    logic        e_ops  = 1'b0;
    logic [31:0] e_a    = '0;
    logic [31:0] e_b    = '0;
    logic        e_sa   = 1'b0;
    logic        e_sb   = 1'b0;

    // shadow of the product cache
    logic        mc_valid = 1'b0;
    logic [31:0] mc_a     = '0;
    logic [31:0] mc_b     = '0;
    logic        mc_sa    = 1'b0;
    logic        mc_sb    = 1'b0;

    logic [31:0] last_resp;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic sgn_a(input logic [1:0] op);
        return op != 2'd3;
    endfunction

    function automatic logic sgn_b(input logic [1:0] op);
        return op <= 2'd1;
    endfunction

    function automatic logic [63:0] product(input logic [31:0] a, b,
                                            input logic sa, sb);
        logic [63:0] ax, bx;
        ax = sa ? {{32{a[31]}}, a} : {32'h0, a};
        bx = sb ? {{32{b[31]}}, b} : {32'h0, b};
        return ax * bx;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a, b);
        logic [63:0] p;
        p = product(a, b, sgn_a(op), sgn_b(op));
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic model_hit(input logic [1:0] op,
                                       input logic [31:0] a, b);
        return mc_valid && (a == mc_a) && (b == mc_b) &&
               (((sgn_a(op) == mc_sa) && (sgn_b(op) == mc_sb)) || (op == 2'd0));
    endfunction

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.busy, e_busy);
            check("req_ready", bus.req_ready, !e_busy);
            check("resp_valid", bus.resp_valid, e_rv);
            check("mul_en", bus.mul_en, e_men);
            if (e_rv) check("resp_data", bus.resp_data, e_data);
            if (e_ops) begin
                check("mul_a", bus.mul_a, e_a);
                check("mul_b", bus.mul_b, e_b);
                check("mul_signed_a", bus.mul_signed_a, e_sa);
                check("mul_signed_b", bus.mul_signed_b, e_sb);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic busy_, rv_, men_, input logic [31:0] data_);
        e_busy = busy_;
        e_rv   = rv_;
        e_men  = men_;
        e_data = data_;
    endtask

    task automatic idle_exp();
        set_exp(1'b0, 1'b0, 1'b0, '0);
        e_ops = 1'b0;
    endtask

    // fmode: 0 none, 1 flush with request, 2 flush in ISSUE,
    //        3 flush at WAIT cycle fpos, 4 flush at RESP cycle fpos
    task automatic do_req(input logic [1:0] op, input logic [31:0] a, b,
                          input int dly, stall, fmode, fpos);
        logic        hit;
        logic        drained;
        logic        done;
        logic [31:0] expv;
        hit  = model_hit(op, a, b);
        expv = ref_result(op, a, b);

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.flush     = (fmode == 1);
        idle_exp();
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_rs1   = $urandom;
        bus.req_rs2   = $urandom;
        if (fmode == 1) begin
            idle_exp();
            return;
        end

        if (hit) begin
            set_exp(1'b1, 1'b1, 1'b0, expv);
        end else begin
            // ISSUE: a stray mul_ready here must be ignored
            set_exp(1'b1, 1'b0, 1'b1, '0);
            e_ops = 1'b1;
            e_a   = a;
            e_b   = b;
            e_sa  = sgn_a(op);
            e_sb  = sgn_b(op);
            bus.mul_ready = 1'($urandom_range(0, 1));
            bus.mul_out   = {$urandom, $urandom};
            bus.flush     = (fmode == 2);
            step();
            bus.mul_ready = 1'b0;
            drained = (fmode == 2);
            set_exp(1'b1, 1'b0, 1'b0, '0);
            for (int i = 0; i < dly; i++) begin
                if (drained) bus.flush = 1'($urandom_range(0, 1));
                else         bus.flush = (fmode == 3) && (i == fpos);
                step();
                if (bus.flush) drained = 1'b1;
                bus.flush = 1'b0;
            end
            bus.mul_ready = 1'b1;
            bus.mul_out   = product(bus.mul_a, bus.mul_b,
                                    bus.mul_signed_a, bus.mul_signed_b);
            bus.flush     = drained ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            bus.mul_ready = 1'b0;
            bus.mul_out   = {$urandom, $urandom};
            bus.flush     = 1'b0;
            e_ops         = 1'b0;
            if (drained) begin
                idle_exp();
                return;
            end
            mc_valid = 1'b1;
            mc_a     = a;
            mc_b     = b;
            mc_sa    = sgn_a(op);
            mc_sb    = sgn_b(op);
            set_exp(1'b1, 1'b1, 1'b0, expv);
        end

        done = 1'b0;
        for (int i = 0; i <= stall && !done; i++) begin
            last_resp = bus.resp_data;
            if (fmode == 4 && i == fpos) begin
                bus.flush      = 1'b1;
                bus.resp_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.resp_ready = (i == stall);
            end
            step();
            if (bus.flush || bus.resp_ready) done = 1'b1;
        end
        bus.resp_ready = 1'b0;
        bus.flush      = 1'b0;
        idle_exp();
    endtask

    task automatic reset_pulse();
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst      = 1'b0;
        mc_valid = 1'b0;
        step();
        idle_exp();
        chk_en = 1'b1;
    endtask

    task automatic reset_mid_wait(input logic [1:0] op, input logic [31:0] a, b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        idle_exp();
        step();
        bus.req_valid = 1'b0;
        set_exp(1'b1, 1'b0, 1'b1, '0);
        step();
        set_exp(1'b1, 1'b0, 1'b0, '0);
        step();
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_mul_en", bus.mul_en, 1'b0);
        check("rst_mid_resp_valid", bus.resp_valid, 1'b0);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_req_ready", bus.req_ready, 1'b1);
        check("rst_mid_mul_a", bus.mul_a, 32'h0);
        @(negedge clk);
        #1;
        rst      = 1'b0;
        mc_valid = 1'b0;
        step();
        idle_exp();
        chk_en = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int          dly, stall, fmode, fpos, r;

        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        bus.mul_ready  = 1'b0;
        bus.mul_out    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_resp_valid", bus.resp_valid, 1'b0);
        check("reset_mul_en", bus.mul_en, 1'b0);
        check("reset_resp_data", bus.resp_data, 32'h0);
        check("reset_mul_a", bus.mul_a, 32'h0);
        check("reset_mul_b", bus.mul_b, 32'h0);
        check("reset_signed_a", bus.mul_signed_a, 1'b0);
        check("reset_signed_b", bus.mul_signed_b, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        idle_exp();
        chk_en = 1'b1;

        // MUL 7*6, multiplier done five cycles after the start pulse
        do_req(2'd0, 32'd7, 32'd6, 4, 0, 0, 0);
        check("t1_mul_7x6", last_resp, 32'd42);

        // sign cases on all-ones operands
        reset_pulse();
        do_req(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0, 0);
        check("t2_mulh", last_resp, 32'h0000_0000);
        reset_pulse();
        do_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0);
        check("t2_mulhu", last_resp, 32'hFFFF_FFFE);
        reset_pulse();
        do_req(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 0);
        check("t2_mulhsu", last_resp, 32'hFFFF_FFFF);

        // fused MULH -> MUL hit, then MULHU misses
        reset_pulse();
        do_req(2'd1, 32'h8000_0000, 32'h8000_0000, 3, 0, 0, 0);
        check("t3_mulh", last_resp, 32'h4000_0000);
        do_req(2'd0, 32'h8000_0000, 32'h8000_0000, 3, 0, 0, 0);
        check("t3_mul_hit", last_resp, 32'h0000_0000);
        do_req(2'd3, 32'h8000_0000, 32'h8000_0000, 2, 0, 0, 0);
        check("t3_mulhu_miss", last_resp, 32'h4000_0000);

        // flush two cycles into WAIT, then the same request misses
        do_req(2'd0, 32'd123, 32'd456, 5, 0, 3, 2);
        do_req(2'd0, 32'd123, 32'd456, 1, 0, 0, 0);
        check("t4_reissue", last_resp, 32'd56088);

        // consumer stalls three cycles, then a flush drops the response
        do_req(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1, 4, 4, 3);
        check("t5_stalled_data", last_resp, 32'h0B00_EA4E);

        // async reset in the middle of WAIT, then the same request misses
        reset_mid_wait(2'd1, 32'd99, 32'd77);
        do_req(2'd1, 32'd99, 32'd77, 2, 0, 0, 0);
        do_req(2'd0, 32'hFFFF_FFFF, 32'd5, 0, 0, 0, 0);
        check("t6_mul_neg", last_resp, 32'hFFFF_FFFB);

        // randomized traffic
        ra = pick();
        rb = pick();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                ra = pick();
                rb = pick();
            end
            dly   = $urandom_range(0, 5);
            stall = $urandom_range(0, 3);
            fmode = 0;
            fpos  = 0;
            r     = $urandom_range(0, 15);
            if (r == 0) fmode = 1;
            else if (r == 1) fmode = 2;
            else if (r == 2 && dly > 0) begin
                fmode = 3;
                fpos  = $urandom_range(0, dly - 1);
            end else if (r == 3) begin
                fmode = 4;
                fpos  = $urandom_range(0, stall);
            end
            do_req(2'($urandom), ra, rb, dly, stall, fmode, fpos);
            if ($urandom_range(0, 3) == 0) begin
                bus.flush = 1'($urandom_range(0, 1));
                idle_exp();
                step();
                bus.flush = 1'b0;
            end
        end

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
